uxn_device_snapshot_reader: RTL
===============================

# uxn_device_snapshot_reader

Reads a contiguous window of device-page RAM through the read-only second port of the dual-port device RAM, one byte per cycle. It delivers the window as a single registered snapshot with a valid/ready handshake. Varvara peripheral engines (screen, audio, console) use it to fetch their register block without stalling the CPU-side port. It also flags whether the snapshot differs from the last one the consumer accepted.

## Interface
Parameters:
- BASE_ADDR, 8'h20, device-page address of the first byte in the window.
- NUM_BYTES, 16, window length in bytes; legal range 1..16.

Ports:
- clk  in  1  single clock; rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a scan; sampled only in IDLE, or in HOLD when snap_ready is also high.
- busy  out  1  high in READ and DRAIN.
- rd_addr  out  8  registered address to the RAM read port.
- rd_data  in  8  RAM read-port data; registered in the RAM, valid one cycle after rd_addr is sampled.
- snap_valid  out  1  snapshot available.
- snap_ready  in  1  consumer accepts the snapshot.
- snap_data  out  8*NUM_BYTES  snapshot contents, big-endian; the byte at BASE_ADDR is in the top byte.
- snap_changed  out  1  snapshot differs from the last accepted snapshot.

## Operation
- States:
  - IDLE: waits for a scan request.
  - READ: issues one address per cycle, NUM_BYTES cycles.
  - DRAIN: captures the final byte, one cycle.
  - HOLD: snap_valid high; waits for the handshake.
- IDLE & start: go to READ with issue index 0; rd_addr = BASE_ADDR.
- READ: rd_addr = (BASE_ADDR + i) mod 256 (8-bit wrap, no carry); issue index i advances every cycle.
  - After index NUM_BYTES-1 is issued, go to DRAIN.
- Capture index j runs one cycle behind the issue index.
  - Each rd_data byte is written to an internal capture buffer at slot j.
  - snap_data is not touched during a scan.
- DRAIN: capture the last byte, then go to HOLD.
  - On that edge: snap_data <= completed capture image; snap_changed <= (image != accepted reference); snap_valid <= 1.
- HOLD, snap_ready & !start:
  - Handshake; go to IDLE.
  - snap_valid <= 0; accepted reference <= snap_data.
  - snap_data and snap_changed hold their values.
- HOLD, snap_ready & start: handshake as above plus an immediate new scan (READ, rd_addr = BASE_ADDR), with no idle cycle between.
- start in READ, DRAIN, or HOLD without snap_ready: ignored; no queuing.
- snap_data and snap_changed are stable for as long as snap_valid is high.

## Timing
- Reset values: state IDLE, rd_addr = BASE_ADDR, busy 0, snap_valid 0, snap_data 0, snap_changed 0, accepted reference 0, capture buffer 0.
- Reset asserted mid-scan aborts the scan. After release the block is in IDLE, snap_valid is 0, and no partial data is visible.
- Latency, counting the start-sampling edge as E0:
  - rd_addr = BASE_ADDR + k after edge E_k, for k = 0..NUM_BYTES-1.
  - The byte from address k is captured at E_{k+2}.
  - snap_valid rises after E_{NUM_BYTES+1}. NUM_BYTES=16 gives 17 cycles.
- busy rises after E0 and falls after E_{NUM_BYTES+1}, on the same edge where snap_valid rises.
- Throughput with snap_ready held high and start held high: one snapshot every NUM_BYTES+2 cycles.
- rd_addr holds its last value outside READ; the RAM read is side-effect free.

## Structure
- Shared package uxn_device_pkg holds:
  - the state enum;
  - device-page base constants, e.g. DEV_SYSTEM_BASE 8'h00, DEV_CONSOLE_BASE 8'h10, DEV_SCREEN_BASE 8'h20, DEV_AUDIO0_BASE 8'h30;
  - the MAX_SNAPSHOT_BYTES = 16 constant.
- No sub-module. The issue/capture counters, the FSM, the capture buffer and the compare stay in one module.
- The bench instantiates the existing dual-port device RAM as the read-port model.

## Test plan
- Reset, then preload RAM 0x20..0x2F with 0x10..0x1F, then pulse start:
  - rd_addr steps 0x20..0x2F on consecutive cycles;
  - snap_valid rises 17 cycles after the start edge;
  - snap_data = 0x101112...1F;
  - snap_changed = 1.
- Accept the snapshot, then rescan unchanged RAM: identical snap_data, snap_changed = 0.
- BASE_ADDR = 8'hF8 with NUM_BYTES = 16: rd_addr sequence F8..FF, 00..07; snap_data top byte = RAM[F8], bottom byte = RAM[07].
- Hold snap_ready low for 10 cycles with start pulsing:
  - snap_valid, snap_data and snap_changed stay constant;
  - no new scan starts.
- In HOLD, assert snap_ready and start together:
  - handshake completes;
  - busy is high on the next cycle;
  - the next snap_valid arrives 17 cycles after that edge.
- Assert rst_n low at READ index 7:
  - all outputs return to reset values asynchronously;
  - after release the block stays in IDLE;
  - a new start produces a full, correct snapshot.

Source files
------------

// File: rtl/uxn_device_pkg.sv
// Shared device-page definitions for the Varvara peripheral engines:
// page base addresses, snapshot sizing and the snapshot-reader state encoding.
package uxn_device_pkg;

    localparam logic [7:0] DEV_SYSTEM_BASE  = 8'h00;
    localparam logic [7:0] DEV_CONSOLE_BASE = 8'h10;
    localparam logic [7:0] DEV_SCREEN_BASE  = 8'h20;
    localparam logic [7:0] DEV_AUDIO0_BASE  = 8'h30;

    localparam int MAX_SNAPSHOT_BYTES = 16;
    localparam int SNAP_IDX_W         = $clog2(MAX_SNAPSHOT_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } snap_state_e;

endpackage

// File: rtl/uxn_device_snapshot_reader.sv
// Scans a window of device-page RAM through the read-only RAM port and presents
// it as one registered snapshot with valid/ready, flagging changes since last accept.
module uxn_device_snapshot_reader
    import uxn_device_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = DEV_SCREEN_BASE,
    parameter int         NUM_BYTES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic [7:0]             rd_addr,
    input  logic [7:0]             rd_data,
    output logic                   snap_valid,
    input  logic                   snap_ready,
    output logic [8*NUM_BYTES-1:0] snap_data,
    output logic                   snap_changed
);

    localparam logic [SNAP_IDX_W-1:0] LAST_IDX = SNAP_IDX_W'(NUM_BYTES - 1);

    snap_state_e             state_q;
    logic [SNAP_IDX_W-1:0]   iss_q;
    logic [7:0]              rd_addr_q;
    logic                    busy_q;
    logic                    valid_q;
    logic                    changed_q;
    logic [8*NUM_BYTES-1:0]  snap_q;
    logic [8*NUM_BYTES-1:0]  ref_q;
    logic [7:0]              cap_q [NUM_BYTES];

    logic                    cap_we_d;
    logic [SNAP_IDX_W-1:0]   cap_idx_d;
    logic [8*NUM_BYTES-1:0]  img_d;

    // Capture trails issue by one cycle because the RAM read port is registered.
    always_comb begin
        cap_we_d  = ((state_q == ST_READ) && (iss_q != '0)) || (state_q == ST_DRAIN);
        cap_idx_d = (state_q == ST_DRAIN) ? LAST_IDX : iss_q - 1'b1;
    end

    // Completed image: the last byte comes straight from the RAM on the DRAIN edge.
    always_comb begin
        img_d = '0;
        for (int j = 0; j < NUM_BYTES; j++) begin
            if ((state_q == ST_DRAIN) && (j == NUM_BYTES - 1))
                img_d[8*(NUM_BYTES-1-j) +: 8] = rd_data;
            else
                img_d[8*(NUM_BYTES-1-j) +: 8] = cap_q[j];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            iss_q     <= '0;
            rd_addr_q <= BASE_ADDR;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            snap_q    <= '0;
            ref_q     <= '0;
            for (int j = 0; j < NUM_BYTES; j++) cap_q[j] <= 8'h00;
        end else begin
            if (cap_we_d) cap_q[cap_idx_d] <= rd_data;

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_READ;
                        iss_q     <= '0;
                        rd_addr_q <= BASE_ADDR;
                        busy_q    <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (iss_q == LAST_IDX) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        iss_q     <= iss_q + 1'b1;
                        rd_addr_q <= rd_addr_q + 8'd1;
                    end
                end
                ST_DRAIN: begin
                    snap_q    <= img_d;
                    changed_q <= (img_d != ref_q);
                    valid_q   <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (snap_ready) begin
                        valid_q <= 1'b0;
                        ref_q   <= snap_q;
                        // Accept and restart on the same edge keeps back-to-back scans gapless.
                        if (start) begin
                            state_q   <= ST_READ;
                            iss_q     <= '0;
                            rd_addr_q <= BASE_ADDR;
                            busy_q    <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign rd_addr      = rd_addr_q;
    assign snap_valid   = valid_q;
    assign snap_data    = snap_q;
    assign snap_changed = changed_q;

endmodule
